// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Registered ALU control decoder. Turns the control-unit op
//               class and the R-type funct field into an ALU select code one
//               cycle later, and sequences multi-cycle MULT/DIV operations
//               with a busy/ready handshake and a HI/LO write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [1:0]       ucon,
    output logic [SEL_W-1:0] alu_select,
    output logic             out_valid,
    output logic             busy,
    output logic             hilo_we,
    output logic             err
);

    // Counter sized for the longer of the two multi-cycle operations
    localparam int c_MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_CYCLES - 1);

    // ALU operation codes
    localparam logic [3:0] c_AND  = 4'b0000;
    localparam logic [3:0] c_OR   = 4'b0001;
    localparam logic [3:0] c_ADD  = 4'b0010;
    localparam logic [3:0] c_NOP  = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_NOR  = 4'b0101;
    localparam logic [3:0] c_SUB  = 4'b0110;
    localparam logic [3:0] c_SLT  = 4'b0111;
    localparam logic [3:0] c_SRL  = 4'b1001;
    localparam logic [3:0] c_SRA  = 4'b1010;
    localparam logic [3:0] c_MULT = 4'b1100;
    localparam logic [3:0] c_DIV  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_sel;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_hilo_we;
    logic               r_err;

    logic [3:0]         w_code;
    logic               w_illegal;
    logic               w_accept;

    // Decode op class and funct into an ALU code; unknown R-type funct flags err
    always_comb begin
        w_code    = c_NOP;
        w_illegal = 1'b0;
        case (ucon)
            2'b00: w_code = c_ADD;
            2'b01: w_code = c_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: w_code = c_ADD;
                    6'b100010: w_code = c_SUB;
                    6'b100100: w_code = c_AND;
                    6'b100101: w_code = c_OR;
                    6'b100110: w_code = c_XOR;
                    6'b100111: w_code = c_NOR;
                    6'b101010: w_code = c_SLT;
                    6'b000000: w_code = c_NOP;
                    6'b000010: w_code = c_SRL;
                    6'b000011: w_code = c_SRA;
                    6'b011000: w_code = c_MULT;
                    6'b011010: w_code = c_DIV;
                    default: begin
                        w_code    = c_NOP;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                case (funct[1:0])
                    2'b00:   w_code = c_AND;
                    2'b01:   w_code = c_OR;
                    2'b10:   w_code = c_SLT;
                    default: w_code = c_XOR;
                endcase
            end
        endcase
    end

    // Busy blocks acceptance; flush drops any input presented alongside it
    assign w_accept = in_valid & ~r_busy & ~flush;

    // Control sequencer: single-cycle decode or a counted MULT/DIV busy period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= SEL_W'(c_NOP);
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_err       <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= SEL_W'(c_NOP);
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel <= SEL_W'(w_code);
                        if (w_code == c_MULT) begin
                            r_cnt   <= c_MUL_LOAD;
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else if (w_code == c_DIV) begin
                            r_cnt   <= c_DIV_LOAD;
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_err       <= w_illegal;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_hilo_we   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign alu_select = r_sel;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign hilo_we    = r_hilo_we;
    assign err        = r_err;
    assign in_ready   = ~r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Self-checking bench for alu_ctrl_seq. Two instances share the
//               stimulus: one with an 8-cycle DIV, one with a 1-cycle DIV.
//               A transaction-level model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

    localparam int MUL_N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] funct = 6'd0;
    logic [1:0] ucon = 2'd0;

    logic [3:0] sel_a, sel_b;
    logic       ov_a, ov_b, busy_a, busy_b, rdy_a, rdy_b, hw_a, hw_b, err_a, err_b;

    int vectors = 0;
    int miscompares = 0;

    // Model state per instance: remaining busy cycles, last code, pulse outputs
    int         m_left [2];
    int         n_div  [2];
    logic [3:0] m_sel  [2];
    logic       m_ov   [2];
    logic       m_hw   [2];
    logic       m_err  [2];

    alu_ctrl_seq #(.SEL_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_a), .funct(funct), .ucon(ucon), .alu_select(sel_a),
        .out_valid(ov_a), .busy(busy_a), .hilo_we(hw_a), .err(err_a)
    );

    alu_ctrl_seq #(.SEL_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_b), .funct(funct), .ucon(ucon), .alu_select(sel_b),
        .out_valid(ov_b), .busy(busy_b), .hilo_we(hw_b), .err(err_b)
    );

    always #5 clk = ~clk;

    // Returns {err, code} straight from the decode table
    function automatic logic [4:0] decode(input logic [1:0] u, input logic [5:0] f);
        logic [4:0] r;
        r = {1'b0, 4'b0011};
        if (u == 2'b00) r = {1'b0, 4'b0010};
        else if (u == 2'b01) r = {1'b0, 4'b0110};
        else if (u == 2'b11) begin
            if (f[1:0] == 2'b00) r = {1'b0, 4'b0000};
            else if (f[1:0] == 2'b01) r = {1'b0, 4'b0001};
            else if (f[1:0] == 2'b10) r = {1'b0, 4'b0111};
            else r = {1'b0, 4'b0100};
        end else begin
            case (f)
                6'b100000: r = {1'b0, 4'b0010};
                6'b100010: r = {1'b0, 4'b0110};
                6'b100100: r = {1'b0, 4'b0000};
                6'b100101: r = {1'b0, 4'b0001};
                6'b100110: r = {1'b0, 4'b0100};
                6'b100111: r = {1'b0, 4'b0101};
                6'b101010: r = {1'b0, 4'b0111};
                6'b000000: r = {1'b0, 4'b0011};
                6'b000010: r = {1'b0, 4'b1001};
                6'b000011: r = {1'b0, 4'b1010};
                6'b011000: r = {1'b0, 4'b1100};
                6'b011010: r = {1'b0, 4'b1101};
                default:   r = {1'b1, 4'b0011};
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0;
            m_sel[i]  = 4'b0011;
            m_ov[i]   = 1'b0;
            m_hw[i]   = 1'b0;
            m_err[i]  = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge
    task automatic model_edge();
        logic [4:0] d;
        for (int i = 0; i < 2; i++) begin
            m_ov[i]  = 1'b0;
            m_hw[i]  = 1'b0;
            m_err[i] = 1'b0;
            if (flush) begin
                m_left[i] = 0;
                m_sel[i]  = 4'b0011;
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_ov[i] = 1'b1;
                    m_hw[i] = 1'b1;
                end
            end else if (in_valid) begin
                d = decode(ucon, funct);
                m_sel[i] = d[3:0];
                if (d[3:0] == 4'b1100) m_left[i] = MUL_N;
                else if (d[3:0] == 4'b1101) m_left[i] = n_div[i];
                else begin
                    m_ov[i]  = 1'b1;
                    m_err[i] = d[4];
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk    ("a.alu_select", sel_a, m_sel[0]);
        chk_bit("a.out_valid", ov_a, m_ov[0]);
        chk_bit("a.busy", busy_a, m_left[0] > 0);
        chk_bit("a.in_ready", rdy_a, m_left[0] == 0);
        chk_bit("a.hilo_we", hw_a, m_hw[0]);
        chk_bit("a.err", err_a, m_err[0]);
        chk    ("b.alu_select", sel_b, m_sel[1]);
        chk_bit("b.out_valid", ov_b, m_ov[1]);
        chk_bit("b.busy", busy_b, m_left[1] > 0);
        chk_bit("b.in_ready", rdy_b, m_left[1] == 0);
        chk_bit("b.hilo_we", hw_b, m_hw[1]);
        chk_bit("b.err", err_b, m_err[1]);
    endtask

    // One clock: drive inputs, take the edge, update model, compare after edge
    task automatic cycle(input logic v, input logic [1:0] u, input logic [5:0] f, input logic fl);
        in_valid = v;
        ucon     = u;
        funct    = f;
        flush    = fl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    logic [5:0] sweep [10];
    logic [5:0] legal [12];

    initial begin
        n_div[0] = 8;
        n_div[1] = 1;
        sweep = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                  6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011};
        legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                  6'b101010, 6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011010};
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset sel", sel_a, 4'b0011);
        chk_bit("reset in_ready", rdy_a, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // R-type sweep, back to back, then illegal funct
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'b10, sweep[i], 1'b0);
            if (sweep[i] == 6'b100111) chk("nor code", sel_a, 4'b0101);
            if (sweep[i] == 6'b000011) chk("sra code", sel_a, 4'b1010);
        end
        cycle(1'b1, 2'b10, 6'b111111, 1'b0);
        chk("illegal code", sel_a, 4'b0011);
        chk_bit("illegal err", err_a, 1'b1);

        // Other op classes
        cycle(1'b1, 2'b00, 6'b101010, 1'b0);
        chk("ucon00", sel_a, 4'b0010);
        cycle(1'b1, 2'b01, 6'b101010, 1'b0);
        chk("ucon01", sel_a, 4'b0110);
        cycle(1'b1, 2'b11, 6'b110110, 1'b0);
        chk("ucon11", sel_a, 4'b0111);

        // MULT: busy 4 cycles, completion after E4, held ADD accepted at E5
        cycle(1'b1, 2'b10, 6'b011000, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) chk_bit("mult busy", busy_a, 1'b1);
            cycle(1'b1, 2'b10, 6'b100000, 1'b0);
            chk("mult sel held", sel_a, 4'b1100);
        end
        chk_bit("mult out_valid", ov_a, 1'b1);
        chk_bit("mult hilo_we", hw_a, 1'b1);
        chk_bit("mult in_ready", rdy_a, 1'b1);
        cycle(1'b1, 2'b10, 6'b100000, 1'b0);
        chk("second accept", sel_a, 4'b0010);
        chk_bit("second valid", ov_a, 1'b1);

        // DIV: 1-cycle instance completes after E1; flush the 8-cycle one at E3
        cycle(1'b1, 2'b10, 6'b011010, 1'b0);
        chk_bit("div1 busy", busy_b, 1'b1);
        cycle(1'b0, 2'b10, 6'b011010, 1'b0);
        chk_bit("div1 hilo_we", hw_b, 1'b1);
        chk("div1 sel", sel_b, 4'b1101);
        cycle(1'b0, 2'b00, 6'b000000, 1'b0);
        cycle(1'b1, 2'b10, 6'b100000, 1'b1);
        chk("flush sel", sel_a, 4'b0011);
        chk_bit("flush out_valid", ov_a, 1'b0);
        chk_bit("flush in_ready", rdy_a, 1'b1);
        repeat (10) cycle(1'b0, 2'b00, 6'b000000, 1'b0);

        // Asynchronous reset in the middle of a MULT
        cycle(1'b1, 2'b10, 6'b011000, 1'b0);
        cycle(1'b0, 2'b00, 6'b000000, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async sel", sel_a, 4'b0011);
        chk_bit("async busy", busy_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) cycle(1'b0, 2'b00, 6'b000000, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic [5:0] f;
            if ($urandom_range(0, 7) == 0) f = 6'($urandom_range(0, 63));
            else f = legal[$urandom_range(0, 11)];
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), f,
                  1'($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
